clkgen_multi: RTL and testbench

- Synthesizable, parametrised multi-channel clock/pulse generator; successor to the behavioural phase/ton/toff clock generator task used in benches.
- Each channel produces a divided clock from `clk` with programmable high time, low time and phase offset, all counted in `clk` cycles.
- Adds per-channel enable, a global phase-align `sync` and glitch-free config update at period boundaries.
- Sits beside the system clock as a stimulus or strobe source for testbenches and FPGA bring-up.

---
 rtl/clkgen_pkg.sv | 19 +
 rtl/clkgen_channel.sv | 112 +++++++++++
 rtl/clkgen_multi.sv | 66 ++++++
 tb/tb_clkgen_multi.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared types for the multi-channel clock/pulse generator.
// The state encoding keeps bit 1 set exactly in HIGH and LOW, so "active" is a single flop bit.
package clkgen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PHASE = 2'b01,
        HIGH  = 2'b10,
        LOW   = 2'b11
    } state_e;

    localparam int CH_IDX_W_MIN = 1;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : CH_IDX_W_MIN;
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One generator channel: FSM, down-counter, shadow config and registered outputs.
// Shadows reload only on start and at period boundaries, so a config write never cuts a pulse short.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [CNT_W-1:0] prog_ton,
    input  logic [CNT_W-1:0] prog_toff,
    input  logic [CNT_W-1:0] prog_phase,
    output state_e           state,
    output logic             clk_out,
    output logic             rise,
    output logic             fall
);

    typedef struct packed {
        logic [CNT_W-1:0] ton;
        logic [CNT_W-1:0] toff;
        logic [CNT_W-1:0] phase;
    } cfg_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    cfg_t             prog;
    cfg_t             sh;
    cfg_t             sh_next;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             hi_next;

    assign prog = {prog_ton, prog_toff, prog_phase};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sh_next    = sh;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (sync || state == IDLE) begin
            sh_next = prog;
            if (prog.phase != '0) begin
                state_next = PHASE;
                cnt_next   = prog.phase - ONE;
            end else if (prog.ton != '0) begin
                state_next = HIGH;
                cnt_next   = prog.ton - ONE;
            end else begin
                state_next = LOW;
                cnt_next   = prog.toff - ONE;
            end
        end else if (cnt != '0) begin
            cnt_next = cnt - ONE;
        end else begin
            case (state)
                PHASE: begin
                    if (sh.ton != '0) begin
                        state_next = HIGH;
                        cnt_next   = sh.ton - ONE;
                    end else begin
                        state_next = LOW;
                        cnt_next   = sh.toff - ONE;
                    end
                end
                HIGH, LOW: begin
                    // End of a HIGH with low time left is mid-period; everything else is a boundary.
                    if (state == HIGH && sh.toff != '0) begin
                        state_next = LOW;
                        cnt_next   = sh.toff - ONE;
                    end else begin
                        sh_next = prog;
                        if (prog.ton != '0) begin
                            state_next = HIGH;
                            cnt_next   = prog.ton - ONE;
                        end else begin
                            state_next = LOW;
                            cnt_next   = prog.toff - ONE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign hi_next = (state_next == HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            clk_out <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            sh      <= sh_next;
            clk_out <= hi_next;
            rise    <= hi_next & ~clk_out;
            fall    <= ~hi_next & clk_out;
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel clock/pulse generator: programmed-config registers, write decode
// and one clkgen_channel per output.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_TON  = 5,
    parameter int DEF_TOFF = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           en,
    input  logic                        sync,
    input  logic                        cfg_we,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]            cfg_ton,
    input  logic [CNT_W-1:0]            cfg_toff,
    input  logic [CNT_W-1:0]            cfg_phase,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           rise,
    output logic [NUM_CH-1:0]           fall,
    output logic [NUM_CH-1:0]           active
);

    logic [CNT_W-1:0] prog_ton   [NUM_CH];
    logic [CNT_W-1:0] prog_toff  [NUM_CH];
    logic [CNT_W-1:0] prog_phase [NUM_CH];
    state_e           ch_state   [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                prog_ton[i]   <= CNT_W'(DEF_TON);
                prog_toff[i]  <= CNT_W'(DEF_TOFF);
                prog_phase[i] <= '0;
            end
        end else if (cfg_we && int'(cfg_ch) < NUM_CH) begin
            prog_ton[cfg_ch]   <= cfg_ton;
            prog_toff[cfg_ch]  <= cfg_toff;
            prog_phase[cfg_ch] <= cfg_phase;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkgen_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en[i]),
            .sync       (sync),
            .prog_ton   (prog_ton[i]),
            .prog_toff  (prog_toff[i]),
            .prog_phase (prog_phase[i]),
            .state      (ch_state[i]),
            .clk_out    (clk_out[i]),
            .rise       (rise[i]),
            .fall       (fall[i])
        );

        // Decodes to state bit 1, i.e. straight from the channel's state flop.
        assign active[i] = (ch_state[i] == HIGH) || (ch_state[i] == LOW);
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi: captures per-channel waveforms over a window
// and compares them with hand-computed bit patterns (bit k = sample after edge E0+k).
module tb_clkgen_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_ton;
    logic [CNT_W-1:0]  cfg_toff;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] active;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] cap_co [NUM_CH];
    logic [63:0] cap_rs [NUM_CH];
    logic [63:0] cap_fl [NUM_CH];
    logic [63:0] cap_ac [NUM_CH];

    clkgen_multi #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DEF_TON  (5),
        .DEF_TOFF (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_ton   (cfg_ton),
        .cfg_toff  (cfg_toff),
        .cfg_phase (cfg_phase),
        .clk_out   (clk_out),
        .rise      (rise),
        .fall      (fall),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs change on the negedge; the write lands on the following posedge.
    task automatic cfg_write(input int ch, input int ton, input int toff, input int ph);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_ton   = CNT_W'(ton);
        cfg_toff  = CNT_W'(toff);
        cfg_phase = CNT_W'(ph);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Samples n cycles on the negedge; one-cycle strobes (sync, cfg_we) drop after the first.
    task automatic capture(input int n);
        for (int c = 0; c < NUM_CH; c++) begin
            cap_co[c] = '0;
            cap_rs[c] = '0;
            cap_fl[c] = '0;
            cap_ac[c] = '0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                cap_co[c][k] = clk_out[c];
                cap_rs[c][k] = rise[c];
                cap_fl[c][k] = fall[c];
                cap_ac[c][k] = active[c];
            end
            sync   = 1'b0;
            cfg_we = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = '0;
        sync      = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_ton   = '0;
        cfg_toff  = '0;
        cfg_phase = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {48'd0, clk_out, rise, fall, active}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {48'd0, clk_out, rise, fall, active}, 64'd0);

        // Defaults 5/5, phase 0: high right after E0.
        en = 4'b0001;
        capture(20);
        check("def_clk_out", cap_co[0], 64'h07C1F);
        check("def_rise",    cap_rs[0], 64'h00401);
        check("def_fall",    cap_fl[0], 64'h08020);
        check("def_active",  cap_ac[0], 64'hFFFFF);

        // Write 3/1 two cycles into a HIGH; current 5/5 period must finish first.
        capture(2);
        cfg_write(0, 3, 1, 0);
        capture(16);
        check("bnd_clk_out", cap_co[0], 64'hBB83);
        check("bnd_rise",    cap_rs[0], 64'h8880);
        check("bnd_fall",    cap_fl[0], 64'h4404);
        check("bnd_no_both", cap_rs[0] & cap_fl[0], 64'h0);

        // Phase offset: ch1 2/6/3, ch2 4/4/0 enabled together.
        en = '0;
        cfg_write(1, 2, 6, 3);
        cfg_write(2, 4, 4, 0);
        en = 4'b0110;
        capture(16);
        check("ph_ch2_clk",    cap_co[2], 64'h0F0F);
        check("ph_ch1_clk",    cap_co[1], 64'h1818);
        check("ph_ch1_rise",   cap_rs[1], 64'h0808);
        check("ph_ch1_active", cap_ac[1], 64'hFFF8);

        // Degenerate: ch0 ton=0, ch3 ton=4 toff=0 phase=1.
        en = '0;
        cfg_write(0, 0, 3, 0);
        cfg_write(3, 4, 0, 1);
        en = 4'b1001;
        capture(12);
        check("ton0_clk",    cap_co[0], 64'h0);
        check("ton0_strobe", cap_rs[0] | cap_fl[0], 64'h0);
        check("toff0_clk",   cap_co[3], 64'hFFE);
        check("toff0_rise",  cap_rs[3], 64'h002);
        check("toff0_fall",  cap_fl[3], 64'h0);
        check("toff0_act",   cap_ac[3], 64'hFFE);

        // sync: phases 0/2/5 with 3/3, ch3 disabled.
        en = '0;
        cfg_write(0, 3, 3, 0);
        cfg_write(1, 3, 3, 2);
        cfg_write(2, 3, 3, 5);
        en = 4'b0111;
        repeat (7) @(negedge clk);
        sync = 1'b1;
        capture(12);
        check("sync_ch0", cap_co[0], 64'h1C7);
        check("sync_ch1", cap_co[1], 64'h71C);
        check("sync_ch2", cap_co[2], 64'h8E0);
        check("sync_ch3", cap_co[3] | cap_ac[3], 64'h0);

        // Drop en[0] in the middle of a HIGH.
        capture(1);
        check("dis_pre_high", cap_co[0], 64'h1);
        en = 4'b0110;
        capture(2);
        check("dis_clk",    cap_co[0], 64'h0);
        check("dis_fall",   cap_fl[0], 64'h1);
        check("dis_active", cap_ac[0], 64'h0);

        // Async reset between edges while ch1 is high and ch2 is low.
        @(posedge clk);
        #2;
        check("rst_pre_clk", {60'd0, clk_out}, 64'h2);
        rst_n = 1'b0;
        #1;
        check("rst_async_clk", {60'd0, clk_out}, 64'h0);
        check("rst_async_act", {60'd0, active}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 4'b0010;
        capture(12);
        check("rst_def_ch1", cap_co[1], 64'hC1F);
        check("rst_def_ch2", cap_co[2], 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
